// File: rtl/user_locked_reader.sv
// Owner-checked read port for a protected register; counts denied reads.
// Optional lockout after MAX_VIOL consecutive denials: define READ_LOCKOUT_EN.
module user_locked_reader #(
  parameter int          DATA_W   = 8,
  parameter logic [1:0]  OWNER_ID = 2'h2,
  parameter int          MAX_VIOL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [1:0]        rd_usr_id,
  input  logic [DATA_W-1:0] reg_value,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [7:0]        viol_count,
  output logic              locked
);

  if (MAX_VIOL < 1 || MAX_VIOL > 15) begin : g_max_viol_range
    $error("MAX_VIOL must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [1:0]        id_q, id_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic [7:0]        viol_q, viol_d;
  logic              grant;

`ifdef READ_LOCKOUT_EN
  logic [3:0] streak_q, streak_d;
  logic       locked_q, locked_d;
  logic [4:0] streak_inc;

  // Owner match is overridden by a sticky lockout.
  always_comb begin
    grant      = (id_q == OWNER_ID) && !locked_q;
    streak_inc = {1'b0, streak_q} + 5'd1;
  end

  // Consecutive-denial streak and sticky lock, both resolved at CHECK.
  always_comb begin
    streak_d = streak_q;
    locked_d = locked_q;
    if (state_q == CHECK) begin
      if (grant) begin
        streak_d = 4'd0;
      end else begin
        if (streak_q != 4'hF) begin
          streak_d = streak_inc[3:0];
        end
        if (streak_inc >= 5'(MAX_VIOL)) begin
          locked_d = 1'b1;
        end
      end
    end
  end

  // Lockout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 4'd0;
      locked_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  // Grant depends only on the owner id.
  always_comb begin
    grant = (id_q == OWNER_ID);
  end

  assign locked = 1'b0;
`endif

  // Next state, request snapshot and response content.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    id_d       = id_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    viol_d     = viol_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          snap_d  = reg_value;
          id_d    = rd_usr_id;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = RESP;
        if (grant) begin
          rd_data_d = snap_q;
          rd_err_d  = 1'b0;
        end else begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
          if (viol_q != 8'hFF) begin
            viol_d = viol_q + 8'd1;
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        rd_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      id_q       <= 2'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      viol_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      id_q       <= id_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      viol_q     <= viol_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;
  assign viol_count = viol_q;

endmodule

// File: tb/tb_user_locked_reader.sv
// Bench for user_locked_reader: transaction model, vector table,
// directed corner sequences and random traffic.
module tb_user_locked_reader;

  localparam int         DW  = 8;
  localparam logic [1:0] OWN = 2'h2;
  localparam int         MV  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [1:0]    rd_usr_id = 2'd0;
  logic [DW-1:0] reg_value = 8'hA5;
  logic          busy, rd_valid, rd_err, locked;
  logic [DW-1:0] rd_data;
  logic [7:0]    viol_count;

  always #5 clk = ~clk;

  user_locked_reader #(
    .DATA_W(DW), .OWNER_ID(OWN), .MAX_VIOL(MV)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req),
    .rd_usr_id(rd_usr_id), .reg_value(reg_value),
    .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .viol_count(viol_count), .locked(locked)
  );

  int errs = 0;
  int checks = 0;

  // Transaction-level reference: a request accepted at edge n
  // is decided at edge n+1 and strobed at edge n+2.
  int         e_idx = 0;
  bit         m_pend = 0;
  int         m_n = 0;
  logic [1:0] m_id = '0;
  logic [7:0] m_snap = '0;
  bit         m_valid = 0;
  logic [7:0] m_data = '0;
  bit         m_err = 0;
  int         m_viol = 0;
  bit         m_locked = 0;
  int         m_streak = 0;

  function automatic void model_edge();
    e_idx++;
    if (rst) begin
      m_pend = 0; m_valid = 0; m_data = '0; m_err = 0;
      m_viol = 0; m_locked = 0; m_streak = 0;
      return;
    end
    m_valid = 0;
    if (m_pend && e_idx == m_n + 1) begin
      bit g;
      g = (m_id == OWN) && !m_locked;
      if (g) begin
        m_data = m_snap; m_err = 0; m_streak = 0;
      end else begin
        m_data = '0; m_err = 1;
        m_viol = (m_viol < 255) ? m_viol + 1 : 255;
`ifdef READ_LOCKOUT_EN
        m_streak++;
        if (m_streak >= MV) m_locked = 1;
`endif
      end
    end else if (m_pend && e_idx == m_n + 2) begin
      m_valid = 1; m_pend = 0;
    end else if (!m_pend && rd_req) begin
      m_pend = 1; m_n = e_idx;
      m_id = rd_usr_id; m_snap = reg_value;
    end
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", 32'(busy), 32'(m_pend));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("rd_err", 32'(rd_err), 32'(m_err));
    chk("viol_count", 32'(viol_count), 32'(m_viol));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic do_req(input logic [1:0] id,
                        input logic [7:0] val,
                        output logic [7:0] d,
                        output logic e);
    bit seen;
    seen = 0;
    rd_req = 1; rd_usr_id = id; reg_value = val;
    step();
    rd_req = 0; reg_value = ~val;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (rd_valid) seen = 1;
    end
    if (!seen) chk("req_timeout", 0, 1);
    d = rd_data; e = rd_err;
  endtask

  task automatic do_reset();
    rst = 1; rd_req = 0;
    step(); step();
    rst = 0;
  endtask

  typedef struct {
    logic [1:0] id;
    logic [7:0] val;
    logic       err;
    logic       lk;
    int         viol;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] d;
    logic       e;
    int         nv;

`ifdef READ_LOCKOUT_EN
    tbl[0] = '{2'd0, 8'h11, 1, 0, 1};
    tbl[1] = '{2'd3, 8'h22, 1, 0, 2};
    tbl[2] = '{2'd2, 8'h33, 0, 0, 2};
    tbl[3] = '{2'd1, 8'h44, 1, 0, 3};
    tbl[4] = '{2'd0, 8'h55, 1, 0, 4};
    tbl[5] = '{2'd3, 8'h66, 1, 1, 5};
    tbl[6] = '{2'd2, 8'h77, 1, 1, 6};
`else
    tbl[0] = '{2'd0, 8'h11, 1, 0, 1};
    tbl[1] = '{2'd3, 8'h22, 1, 0, 2};
    tbl[2] = '{2'd2, 8'h33, 0, 0, 2};
    tbl[3] = '{2'd1, 8'h44, 1, 0, 3};
    tbl[4] = '{2'd0, 8'h55, 1, 0, 4};
    tbl[5] = '{2'd3, 8'h66, 1, 0, 5};
    tbl[6] = '{2'd2, 8'h77, 0, 0, 5};
`endif

    // Reset and idle quiet period.
    reg_value = 8'hA5;
    do_reset();
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_valid) nv++;
    end
    chk("idle_no_valid", 32'(nv), 0);
    chk("reset_data", 32'(rd_data), 0);

    // Owner read with reg_value changing after acceptance.
    do_req(2'd2, 8'h3C, d, e);
    chk("own_data", 32'(d), 32'h3C);
    chk("own_err", 32'(e), 0);
    chk("own_viol", 32'(viol_count), 0);

    // Denied read; response holds while idle.
    do_req(2'd1, 8'h77, d, e);
    chk("deny_data", 32'(d), 0);
    chk("deny_err", 32'(e), 1);
    chk("deny_viol", 32'(viol_count), 1);
    for (int i = 0; i < 5; i++) step();
    chk("hold_data", 32'(rd_data), 0);
    chk("hold_err", 32'(rd_err), 1);

    // Held request: one response every 3 cycles.
    rd_req = 1; rd_usr_id = 2'd2; reg_value = 8'h5A;
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("held_busy", 32'(busy), 32'(i % 3 != 2));
      if (rd_valid) nv++;
    end
    rd_req = 0;
    chk("held_count", 32'(nv), 3);
    step();

    // Lockout sequence from a clean reset.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_req(tbl[i].id, tbl[i].val, d, e);
      chk("tbl_data", 32'(d),
          tbl[i].err ? 32'd0 : 32'(tbl[i].val));
      chk("tbl_err", 32'(e), 32'(tbl[i].err));
      chk("tbl_locked", 32'(locked), 32'(tbl[i].lk));
      chk("tbl_viol", 32'(viol_count), 32'(tbl[i].viol));
    end
    do_reset();
    chk("rst_unlock", 32'(locked), 0);
    do_req(2'd2, 8'h9E, d, e);
    chk("post_rst_data", 32'(d), 32'h9E);
    chk("post_rst_err", 32'(e), 0);

    // Reset during CHECK drops the request.
    rd_req = 1; rd_usr_id = 2'd2; reg_value = 8'hC3;
    step();
    rd_req = 0; rst = 1;
    step();
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(rd_valid), 0);
    chk("abort_data", 32'(rd_data), 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_valid) nv++;
    end
    chk("abort_no_valid", 32'(nv), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      rd_req = $urandom_range(0, 1);
      rd_usr_id = 2'($urandom_range(0, 3));
      reg_value = 8'($urandom);
      step();
    end
    rst = 0; rd_req = 0;
    step();

    // Violation counter saturates at 255.
    do_reset();
    for (int i = 0; i < 260; i++) do_req(2'd0, 8'h12, d, e);
    chk("viol_sat", 32'(viol_count), 255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
